rf_conv3_sequencer: RTL



---
 rtl/rf_conv3_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rf_conv3_sequencer.sv
// Loads one frame of N samples into an external register file, then sweeps 3-register
// windows through its registered read ports and emits a signed 3-tap convolution per window.
module rf_conv3_sequencer #(
    parameter int M  = 4,
    parameter int N  = 2**M,
    parameter int W  = 8,
    parameter int AW = 2*W+2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  k0,
    input  logic [W-1:0]  k1,
    input  logic [W-1:0]  k2,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          rf_WriteEn,
    output logic [M-1:0]  rf_WriteReg,
    output logic [W-1:0]  rf_WriteData,
    output logic          rf_ReadEn,
    output logic [M-1:0]  rf_ReadReg1,
    output logic [M-1:0]  rf_ReadReg2,
    output logic [M-1:0]  rf_ReadReg3,
    input  logic [W-1:0]  rf_ReadData1,
    input  logic [W-1:0]  rf_ReadData2,
    input  logic [W-1:0]  rf_ReadData3,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SWEEP  = 3'd2,
        S_DRAIN1 = 3'd3,
        S_DRAIN2 = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [M-1:0] LAST_W = M'(N-1);
    localparam logic [M-1:0] LAST_R = M'(N-3);

    state_t state, state_n;
    logic [M-1:0] wcnt, wcnt_n;
    logic [M-1:0] rcnt, rcnt_n;
    logic [W-1:0] k0_q, k1_q, k2_q;
    logic         latch_k;
    logic         rd_v;

    logic signed [2*W-1:0] p0, p1, p2;
    logic signed [AW-1:0]  sum;

    assign dbg_state = state;

    // Input handshake: a sample transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready is high exactly while in LOAD.
    always_comb begin
        state_n      = state;
        wcnt_n       = wcnt;
        rcnt_n       = rcnt;
        latch_k      = 1'b0;
        rf_WriteEn   = 1'b0;
        rf_WriteReg  = '0;
        rf_WriteData = '0;
        rf_ReadEn    = 1'b0;
        rf_ReadReg1  = '0;
        rf_ReadReg2  = '0;
        rf_ReadReg3  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_k = 1'b1;
                    wcnt_n  = '0;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    rf_WriteEn   = 1'b1;
                    rf_WriteReg  = wcnt;
                    rf_WriteData = in_data;
                    wcnt_n       = wcnt + M'(1);
                    if (wcnt == LAST_W) begin
                        rcnt_n  = '0;
                        state_n = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                rf_ReadEn   = 1'b1;
                rf_ReadReg1 = rcnt;
                rf_ReadReg2 = rcnt + M'(1);
                rf_ReadReg3 = rcnt + M'(2);
                rcnt_n      = rcnt + M'(1);
                if (rcnt == LAST_R) begin
                    state_n = S_DRAIN1;
                end
            end
            S_DRAIN1: state_n = S_DRAIN2;
            S_DRAIN2: state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Products are exact at 2W bits; sign extension to AW leaves headroom for the 3-term sum.
    always_comb begin
        p0  = $signed(k0_q) * $signed(rf_ReadData1);
        p1  = $signed(k1_q) * $signed(rf_ReadData2);
        p2  = $signed(k2_q) * $signed(rf_ReadData3);
        sum = $signed({{(AW-2*W){p0[2*W-1]}}, p0})
            + $signed({{(AW-2*W){p1[2*W-1]}}, p1})
            + $signed({{(AW-2*W){p2[2*W-1]}}, p2});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            rcnt      <= '0;
            k0_q      <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
            rd_v      <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            rcnt  <= rcnt_n;
            if (latch_k) begin
                k0_q <= k0;
                k1_q <= k1;
                k2_q <= k2;
            end
            // rd_v marks the cycle in which the register file presents issued read data.
            rd_v      <= rf_ReadEn;
            in_ready  <= (state_n == S_LOAD);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            out_valid <= rd_v;
            if (rd_v) begin
                out_data <= sum;
            end
        end
    end

endmodule
